// File: rtl/rule_collector.sv
// rtl/rule_collector.sv - matched-rule compaction FIFO with per-packet terminators
// Optional statistics counters: define RULE_COLLECTOR_STATS_EN.
module rule_collector #(
  parameter int DEPTH       = 32,
  parameter int AF_THRESH   = 8,
  parameter int RULE_AWIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RULE_AWIDTH-1:0] in_rule_data,
  input  logic                   in_rule_match,
  input  logic                   in_eop,
  output logic                   in_almost_full,
  output logic [RULE_AWIDTH-1:0] out_rule_data,
  output logic                   out_last,
  output logic                   out_trunc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_eop_lost
`ifdef RULE_COLLECTOR_STATS_EN
  ,
  output logic [31:0]            stat_rules_in,
  output logic [31:0]            stat_rules_drop,
  output logic [31:0]            stat_pkts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = RULE_AWIDTH + 2;
  localparam logic [CW-1:0] CNT_TERM_MAX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_RULE_MAX = CW'(DEPTH - 2);

  typedef enum logic {IDLE, IN_PKT} pkt_state_e;

  logic [EW-1:0]          mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CW-1:0]          count_q, count_d;
  logic                   out_valid_q, out_valid_d;
  logic [EW-1:0]          out_entry_q, out_entry_d;
  logic                   err_q, err_d;
  logic                   trunc_pend_q, trunc_pend_d;
  logic                   af_q, af_d;
  pkt_state_e             pkt_state_q, pkt_state_d;

  logic                   match_v, pop, wr_en, term_wr, drop, rule_wr;
  logic [RULE_AWIDTH-1:0] rule_field;
  logic [EW-1:0]          wr_entry;

  always_comb begin
    match_v      = in_rule_match && (in_rule_data != '0);
    pop          = out_valid_q && out_ready;
    rule_field   = match_v ? in_rule_data : '0;
    wr_en        = 1'b0;
    term_wr      = 1'b0;
    rule_wr      = 1'b0;
    drop         = 1'b0;
    wr_entry     = '0;
    err_d        = err_q;
    trunc_pend_d = trunc_pend_q;
    pkt_state_d  = pkt_state_q;

    // Write admission uses the pre-read count; one slot is always held back for the terminator.
    if (in_eop) begin
      pkt_state_d  = IDLE;
      trunc_pend_d = 1'b0;
      if (count_q <= CNT_TERM_MAX) begin
        wr_en    = 1'b1;
        term_wr  = 1'b1;
        rule_wr  = match_v;
        wr_entry = {trunc_pend_q, 1'b1, rule_field};
      end else begin
        err_d = 1'b1;
        drop  = match_v;
      end
    end else if (match_v) begin
      pkt_state_d = IN_PKT;
      if (count_q <= CNT_RULE_MAX) begin
        wr_en    = 1'b1;
        rule_wr  = 1'b1;
        wr_entry = {2'b00, rule_field};
      end else begin
        drop         = 1'b1;
        trunc_pend_d = 1'b1;
      end
    end

    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    rd_next  = rd_ptr_d;
    count_d  = count_q + CW'(wr_en) - CW'(pop);
    af_d     = (DEPTH - int'(count_d)) <= AF_THRESH;

    // Show-ahead register only sees entries committed at earlier edges.
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    if (!out_valid_q || pop) begin
      out_valid_d = (count_q - CW'(pop)) != '0;
      out_entry_d = mem_q[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_entry_q  <= '0;
      err_q        <= 1'b0;
      trunc_pend_q <= 1'b0;
      af_q         <= 1'b0;
      pkt_state_q  <= IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_entry_q  <= out_entry_d;
      err_q        <= err_d;
      trunc_pend_q <= trunc_pend_d;
      af_q         <= af_d;
      pkt_state_q  <= pkt_state_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_trunc      = out_entry_q[EW-1];
  assign out_last       = out_entry_q[EW-2];
  assign out_rule_data  = out_entry_q[RULE_AWIDTH-1:0];
  assign err_eop_lost   = err_q;
  assign in_almost_full = af_q;

`ifdef RULE_COLLECTOR_STATS_EN
  logic [31:0] st_in_q, st_drop_q, st_pkts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_in_q   <= '0;
      st_drop_q <= '0;
      st_pkts_q <= '0;
    end else begin
      st_in_q   <= st_in_q + 32'(rule_wr);
      st_drop_q <= st_drop_q + 32'(drop);
      st_pkts_q <= st_pkts_q + 32'(term_wr);
    end
  end

  assign stat_rules_in   = st_in_q;
  assign stat_rules_drop = st_drop_q;
  assign stat_pkts       = st_pkts_q;
`endif

endmodule

// File: tb/tb_rule_collector.sv
// tb/tb_rule_collector.sv - bench for rule_collector (DEPTH=4) with queue scoreboard and directed literals
module tb_rule_collector;
  localparam int DEPTH = 4;
  localparam int AFT   = 2;
  localparam int RW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] in_rule_data = '0;
  logic          in_rule_match = 1'b0, in_eop = 1'b0, out_ready = 1'b0;
  logic          in_almost_full, out_last, out_trunc, out_valid, err_eop_lost;
  logic [RW-1:0] out_rule_data;
`ifdef RULE_COLLECTOR_STATS_EN
  logic [31:0]   stat_rules_in, stat_rules_drop, stat_pkts;
`endif

  int checks = 0;
  int failures = 0;

  rule_collector #(.DEPTH(DEPTH), .AF_THRESH(AFT), .RULE_AWIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_rule_data(in_rule_data), .in_rule_match(in_rule_match), .in_eop(in_eop),
    .in_almost_full(in_almost_full),
    .out_rule_data(out_rule_data), .out_last(out_last), .out_trunc(out_trunc),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_eop_lost(err_eop_lost)
`ifdef RULE_COLLECTOR_STATS_EN
    , .stat_rules_in(stat_rules_in), .stat_rules_drop(stat_rules_drop), .stat_pkts(stat_pkts)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: entries in arrival order, stamped with the edge that wrote them.
  typedef struct { logic [RW+1:0] e; int stamp; } ent_t;
  ent_t mq[$];
  int   edge_k = 0;
  logic m_valid = 1'b0, m_af = 1'b0, m_err = 1'b0, m_tp = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_valid = 1'b0; m_af = 1'b0; m_err = 1'b0; m_tp = 1'b0;
    end else begin
      int  cnt;
      logic mv, pop;
      ent_t ne;
      edge_k++;
      cnt = mq.size();
      pop = m_valid && out_ready;
      mv  = in_rule_match && (in_rule_data != 0);
      if (in_eop) begin
        if (cnt <= DEPTH - 1) begin
          ne.e = {m_tp, 1'b1, (mv ? in_rule_data : 8'd0)}; ne.stamp = edge_k;
          mq.push_back(ne);
        end else m_err = 1'b1;
        m_tp = 1'b0;
      end else if (mv) begin
        if (cnt <= DEPTH - 2) begin
          ne.e = {2'b00, in_rule_data}; ne.stamp = edge_k;
          mq.push_back(ne);
        end else m_tp = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      m_valid = (mq.size() > 0) && (mq[0].stamp < edge_k);
      m_af    = (DEPTH - mq.size()) <= AFT;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (out_valid !== m_valid) begin
      failures++; $display("FAIL model_valid t=%0t got=%b exp=%b", $time, out_valid, m_valid);
    end
    if (m_valid) begin
      checks++;
      if ({out_trunc, out_last, out_rule_data} !== mq[0].e) begin
        failures++; $display("FAIL model_entry t=%0t got=%h exp=%h", $time, {out_trunc, out_last, out_rule_data}, mq[0].e);
      end
    end
    checks++;
    if (in_almost_full !== m_af) begin
      failures++; $display("FAIL model_af t=%0t got=%b exp=%b", $time, in_almost_full, m_af);
    end
    checks++;
    if (err_eop_lost !== m_err) begin
      failures++; $display("FAIL model_err t=%0t got=%b exp=%b", $time, err_eop_lost, m_err);
    end
  end

  task automatic step(input logic m, input logic [RW-1:0] d, input logic e, input logic r);
    in_rule_match = m; in_rule_data = d; in_eop = e; out_ready = r;
    @(posedge clk); #2;
  endtask

  task automatic lit(input string name, input logic v, input logic [RW-1:0] d, input logic l, input logic t);
    checks++;
    if (out_valid !== v || (v && {out_trunc, out_last, out_rule_data} !== {t, l, d})) begin
      failures++;
      $display("FAIL %s got v=%b d=%0d l=%b t=%b exp v=%b d=%0d l=%b t=%b",
               name, out_valid, out_rule_data, out_last, out_trunc, v, d, l, t);
    end
  endtask

  task automatic lit_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  initial begin
    #12;
    lit("reset_valid", 1'b0, 8'd0, 1'b0, 1'b0);
    lit_bit("reset_af", in_almost_full, 1'b0);
    lit_bit("reset_err", err_eop_lost, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // two matches then bare eop, consumer always ready
    step(1, 8'd5, 0, 1);
    lit("t1_lat_edge1", 1'b0, 8'd0, 1'b0, 1'b0);
    step(1, 8'd9, 0, 1);
    lit("t1_first5", 1'b1, 8'd5, 1'b0, 1'b0);
    step(0, 8'd0, 1, 1);
    lit("t1_then9", 1'b1, 8'd9, 1'b0, 1'b0);
    step(0, 8'd0, 0, 1);
    lit("t1_term", 1'b1, 8'd0, 1'b1, 1'b0);
    step(0, 8'd0, 0, 1);
    lit("t1_empty", 1'b0, 8'd0, 1'b0, 1'b0);

    // eop alone in idle, then match with eop
    step(0, 8'd0, 1, 1);
    step(0, 8'd0, 0, 1);
    lit("t2_eop_only", 1'b1, 8'd0, 1'b1, 1'b0);
    step(1, 8'd7, 1, 1);
    lit("t2_drained", 1'b0, 8'd0, 1'b0, 1'b0);
    step(0, 8'd0, 0, 1);
    lit("t3_match_eop", 1'b1, 8'd7, 1'b1, 1'b0);
    step(1, 8'd0, 0, 1);  // zero ID is not a match
    step(0, 8'd0, 0, 1);
    lit("t3_zero_id", 1'b0, 8'd0, 1'b0, 1'b0);

    // fill with consumer stalled: rule 4 dropped, truncated terminator
    step(1, 8'd1, 0, 0);
    lit_bit("t4_af_cnt1", in_almost_full, 1'b0);
    step(1, 8'd2, 0, 0);
    lit_bit("t4_af_cnt2", in_almost_full, 1'b1);
    step(1, 8'd3, 0, 0);
    step(1, 8'd4, 0, 0);
    step(0, 8'd0, 1, 0);
    lit("t4_head_hold", 1'b1, 8'd1, 1'b0, 1'b0);
    lit_bit("t4_no_err_yet", err_eop_lost, 1'b0);
    step(0, 8'd0, 1, 0);
    lit_bit("t5_err_set", err_eop_lost, 1'b1);
    step(0, 8'd0, 0, 1);
    step(0, 8'd0, 0, 1);
    step(0, 8'd0, 0, 1);
    lit("t4_trunc_term", 1'b1, 8'd0, 1'b1, 1'b1);
    step(0, 8'd0, 0, 1);
    lit("t5_contents_unchanged", 1'b0, 8'd0, 1'b0, 1'b0);
    lit_bit("t5_err_sticky", err_eop_lost, 1'b1);

    // mixed traffic, intermittent ready, checked by the scoreboard
    for (int i = 0; i < 48; i++) begin
      step((i % 3) != 2, RW'((i * 7) % 11), (i % 5) == 4, (i % 4) != 1);
    end
    for (int i = 0; i < 8; i++) step(0, 8'd0, 0, 1);

    // reset mid-packet
    step(1, 8'd6, 0, 0);
    step(1, 8'd8, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #2;
    lit("t6_reset_valid", 1'b0, 8'd0, 1'b0, 1'b0);
    lit_bit("t6_reset_err", err_eop_lost, 1'b0);
    rst_n = 1'b1;
    step(0, 8'd0, 1, 1);
    step(0, 8'd0, 0, 1);
    lit("t6_post_term", 1'b1, 8'd0, 1'b1, 1'b0);
    step(0, 8'd0, 0, 1);
    lit("t6_single", 1'b0, 8'd0, 1'b0, 1'b0);
    step(0, 8'd0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rule_collector.md
Name: rule_collector

Overview:
- Sits directly downstream of the rule/port-group match stage and consumes its per-cycle matched-rule stream (rule ID + match strobe), qualified by a packet-boundary marker aligned to that stream.
- Compacts matched rule IDs into a FIFO and appends a per-packet terminator entry, so each packet produces exactly one `last`.
- Presents the result on a ready/valid interface to the packet/rule reassembly logic.
- Raises an almost-full signal so upstream can stall rule issue.

Parameters:
- DEPTH, 32: FIFO entries; power of two, at least 4.
- AF_THRESH, 8: in_almost_full asserts when free entries are at or below this value.
- RULE_AWIDTH, global from struct_s: rule ID width. Rule ID 0 means "no rule".

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_rule_data  in  RULE_AWIDTH  matched rule ID; used only when in_rule_match=1.
- in_rule_match  in  1  rule slot matched this cycle.
- in_eop  in  1  this cycle is the last rule slot of the current packet.
- in_almost_full  out  1  upstream stall request.
- out_rule_data  out  RULE_AWIDTH  rule ID, or 0 on a terminator entry.
- out_last  out  1  final entry of the packet.
- out_trunc  out  1  valid with out_last; at least one rule of this packet was dropped.
- out_valid  out  1  entry available.
- out_ready  in  1  consumer accepts the entry.
- err_eop_lost  out  1  sticky; a packet terminator could not be stored.

Behaviour:
- Reset: asynchronous on rst_n low, released synchronously. All of the following clear to 0: pointers, count, out_valid, out_rule_data, out_last, out_trunc, err_eop_lost, trunc_pend, pkt_state. in_almost_full resets to 0.
- Entry format: {trunc, last, rule}, width RULE_AWIDTH+2.
- Packet FSM (pkt_state):
  - IDLE -> IN_PKT on an accepted match without eop.
  - IN_PKT -> IDLE on eop.
  - IDLE stays IDLE on an eop-only cycle; that case writes a zero-rule terminator.
  - trunc_pend sets on any drop and clears when the terminator is written.
- Write rules, evaluated against `count` at the clock edge, before any same-cycle read:
  - Match, no eop: write {0,0,id} if count <= DEPTH-2. One slot stays reserved for the terminator. Otherwise drop the rule and set trunc_pend.
  - Match with eop: write {trunc_pend,1,id} if count <= DEPTH-1.
  - Eop, no match: write {trunc_pend,1,0} if count <= DEPTH-1.
  - Eop with count == DEPTH: nothing written, err_eop_lost sets, trunc_pend clears, FSM returns to IDLE.
  - Match with in_rule_data == 0: treat as no match.
- Read: the entry pops when out_valid && out_ready.
  - Simultaneous read and write are both honoured; count is unchanged.
  - A read when count==0 is ignored.
- Latency: an input sampled at edge N appears with out_valid=1 after edge N+1 if the FIFO was empty. Outputs are registered (show-ahead output register fed from RAM).
- Output stability: while out_valid=1 and out_ready=0, out_rule_data, out_last and out_trunc hold stable.
- in_almost_full is registered: `(DEPTH - count_next) <= AF_THRESH`.
- Count width is clog2(DEPTH)+1. Pointers are clog2(DEPTH) bits and wrap naturally.
- Reset mid-packet: the partial packet is discarded and no terminator is emitted.

Optional Feature:
- Macro: RULE_COLLECTOR_STATS_EN.
- When defined, adds outputs stat_rules_in, stat_rules_drop and stat_pkts, each 32 bits, wrapping.
  - stat_rules_in counts accepted non-zero matches.
  - stat_rules_drop counts dropped rules.
  - stat_pkts counts terminators written.
  - All three reset to 0.
- When not defined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Matches 5, 9 on consecutive cycles, then eop alone, with out_ready=1 → entries (5,0,0), (9,0,0), (0,1,0). out_valid first rises 2 edges after rule 5 is presented.
- Eop-only cycle in IDLE → single entry (0,last=1,trunc=0); pkt_state stays IDLE.
- Match 7 with eop in the same cycle → single entry (7,last=1,trunc=0).
- DEPTH=4, out_ready=0, matches 1,2,3,4 then eop → entries 1,2,3 stored and rule 4 dropped; terminator (0,1,trunc=1) written. in_almost_full=1 once free <= AF_THRESH.
- Full FIFO (count=4) plus eop → err_eop_lost=1 and stays 1 until rst_n low; FIFO contents unchanged.
- rst_n low mid-packet after 2 matches → out_valid=0 next cycle. After release, eop alone yields exactly one (0,1,0) entry.
